icon_plotter: RTL and testbench

Drives one slot-reel icon onto the screen. On a `start` pulse it latches an icon index and a screen origin, then sweeps the sprite ROM address space pixel by pixel. It compensates for the one-cycle synchronous ROM read and emits one `plot` strobe per pixel with screen coordinates and colour. It sits between the reel controller (upstream, supplies icon and origin) and the VGA adapter (downstream), wrapping the icon colour-lookup stage that returns `rom_color`.

---
 rtl/icon_plotter.sv | 129 ++++++++++++
 tb/tb_icon_plotter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icon_plotter.sv
// icon_plotter: sweeps one sprite icon through the synchronous colour ROM in
// row-major order and emits one plot strobe per pixel for the VGA adapter.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; icon and origin are latched on acceptance
// DRAW  | issuing one ROM address per cycle, pixel coordinates delayed 1 stage
// FLUSH | last pixel's colour is returning; address held, no new issue
// DONE  | one-cycle done pulse, busy already low
module icon_plotter #(
    parameter int SPRITE_W = 40,
    parameter int SPRITE_H = 40
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  icon_in,
    input  logic [7:0]  x_origin,
    input  logic [6:0]  y_origin,
    input  logic [2:0]  rom_color,
    output logic [2:0]  icon_out,
    output logic [10:0] rom_address,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam logic [10:0] LAST_ADDR = 11'(SPRITE_W * SPRITE_H - 1);
    localparam logic [10:0] LAST_COL  = 11'(SPRITE_W - 1);

    typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [10:0] addr;
    logic [10:0] col;
    logic [10:0] row;
    logic [2:0]  icon_q;
    logic [7:0]  x_org;
    logic [6:0]  y_org;
    // One-stage delay matching the ROM read latency
    logic        d_valid;
    logic [7:0]  d_col;
    logic [6:0]  d_row;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  if (start) state_next = DRAW;
            DRAW: begin
                busy = 1'b1;
                if (addr == LAST_ADDR) state_next = FLUSH;
            end
            FLUSH: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Sweep counters, latched request and pixel delay stage
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr    <= '0;
            col     <= '0;
            row     <= '0;
            icon_q  <= '0;
            x_org   <= '0;
            y_org   <= '0;
            d_valid <= 1'b0;
            d_col   <= '0;
            d_row   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    d_valid <= 1'b0;
                    if (start) begin
                        icon_q <= icon_in;
                        x_org  <= x_origin;
                        y_org  <= y_origin;
                        addr   <= '0;
                        col    <= '0;
                        row    <= '0;
                    end
                end
                DRAW: begin
                    d_valid <= 1'b1;
                    d_col   <= col[7:0];
                    d_row   <= row[6:0];
                    // Address parks on the last pixel so it holds through FLUSH
                    if (addr != LAST_ADDR) addr <= addr + 11'd1;
                    if (col == LAST_COL) begin
                        col <= '0;
                        row <= row + 11'd1;
                    end else begin
                        col <= col + 11'd1;
                    end
                end
                default: d_valid <= 1'b0;
            endcase
        end
    end

    // Screen coordinates wrap naturally through the 8-/7-bit adds
    assign rom_address = addr;
    assign icon_out    = icon_q;
    assign plot        = d_valid;
    assign x           = x_org + d_col;
    assign y           = y_org + d_row;
    assign colour      = rom_color;

endmodule

// File: tb/tb_icon_plotter.sv
// Testbench for icon_plotter: synchronous ROM model returning address[2:0],
// pixel-by-pixel reference computed from raster-order arithmetic.
module tb_icon_plotter;

    localparam int W = 40;
    localparam int H = 40;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [2:0]  icon_in;
    logic [7:0]  x_origin;
    logic [6:0]  y_origin;
    logic [2:0]  rom_color = '0;
    logic [2:0]  icon_out;
    logic [10:0] rom_address;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    logic [7:0] cap_x [N];
    logic [6:0] cap_y [N];
    logic [2:0] cap_c [N];
    int n_plots;

    icon_plotter #(.SPRITE_W(W), .SPRITE_H(H)) dut (
        .clk(clk), .resetn(resetn), .start(start), .icon_in(icon_in),
        .x_origin(x_origin), .y_origin(y_origin), .rom_color(rom_color),
        .icon_out(icon_out), .rom_address(rom_address), .x(x), .y(y),
        .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: one-cycle read latency
    always @(posedge clk) rom_color <= rom_address[2:0];

    function automatic logic [7:0] exp_x(input logic [7:0] ox, input int k);
        int t;
        t = int'(ox) + (k % W);
        return t[7:0];
    endfunction

    function automatic logic [6:0] exp_y(input logic [6:0] oy, input int k);
        int t;
        t = int'(oy) + (k / W);
        return t[6:0];
    endfunction

    // Full sweep from an idle DUT; optional re-pulse of start mid-sweep
    task automatic sweep(input logic [2:0] ic, input logic [7:0] ox,
                         input logic [6:0] oy, input int repulse_at);
        int bad_flags = 0, bad_addr = 0, bad_icon = 0, bad_pix = 0, dones = 0;
        string f_flags = "", f_addr = "", f_icon = "", f_pix = "";
        logic eplot, ebusy, edone;
        logic [10:0] eaddr;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        n_plots = 0;
        icon_in = ic; x_origin = ox; y_origin = oy; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        icon_in = 3'($urandom); x_origin = 8'($urandom); y_origin = 7'($urandom);
        for (int c = 0; c <= N + 2; c++) begin
            eplot = (c >= 1) && (c <= N);
            ebusy = (c <= N);
            edone = (c == N + 1);
            eaddr = (c < N) ? 11'(c) : 11'(N - 1);
            if ({plot, busy, done} !== {eplot, ebusy, edone}) begin
                if (bad_flags == 0)
                    f_flags = $sformatf("c=%0d plot/busy/done=%b%b%b want %b%b%b",
                                        c, plot, busy, done, eplot, ebusy, edone);
                bad_flags++;
            end
            if (rom_address !== eaddr) begin
                if (bad_addr == 0)
                    f_addr = $sformatf("c=%0d rom_address=%0d want %0d", c, rom_address, eaddr);
                bad_addr++;
            end
            if (icon_out !== ic) begin
                if (bad_icon == 0)
                    f_icon = $sformatf("c=%0d icon_out=%0d want %0d", c, icon_out, ic);
                bad_icon++;
            end
            if (done === 1'b1) dones++;
            if (plot === 1'b1 && n_plots < N) begin
                cap_x[n_plots] = x;
                cap_y[n_plots] = y;
                cap_c[n_plots] = colour;
                ex = exp_x(ox, n_plots);
                ey = exp_y(oy, n_plots);
                ec = 3'(n_plots % 8);
                if ({x, y, colour} !== {ex, ey, ec}) begin
                    if (bad_pix == 0)
                        f_pix = $sformatf("pixel %0d got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                                          n_plots, x, y, colour, ex, ey, ec);
                    bad_pix++;
                end
                n_plots++;
            end
            if (c == repulse_at) begin
                start = 1'b1; icon_in = 3'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (bad_flags !== 0) begin failures++; $display("FAIL sweep_flags: %0d bad cycles, %s", bad_flags, f_flags); end
        checks++;
        if (bad_addr !== 0) begin failures++; $display("FAIL sweep_addr: %0d bad cycles, %s", bad_addr, f_addr); end
        checks++;
        if (bad_icon !== 0) begin failures++; $display("FAIL sweep_icon: %0d bad cycles, %s", bad_icon, f_icon); end
        checks++;
        if (bad_pix !== 0) begin failures++; $display("FAIL sweep_pixels: %0d bad pixels, %s", bad_pix, f_pix); end
        checks++;
        if (n_plots !== N) begin failures++; $display("FAIL plot_count: got %0d want %0d", n_plots, N); end
        checks++;
        if (dones !== 1) begin failures++; $display("FAIL done_count: got %0d want 1", dones); end
        checks++;
        if ({busy, plot} !== 2'b00) begin
            failures++; $display("FAIL idle_after: busy/plot=%b%b want 00", busy, plot);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b1; icon_in = 3'd7; x_origin = 8'd99; y_origin = 7'd33;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({plot, busy, done, rom_address, icon_out} !== 16'h0000) begin
                failures++;
                $display("FAIL reset_hold: plot=%b busy=%b done=%b addr=%0d icon=%0d want all 0",
                         plot, busy, done, rom_address, icon_out);
            end
        end
        resetn = 1'b1; start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        sweep(3'd3, 8'd20, 7'd10, -1);
        checks++;
        if ({cap_x[0], cap_y[0], cap_c[0]} !== {8'd20, 7'd10, 3'd0}) begin
            failures++; $display("FAIL first_pixel: got (%0d,%0d,c%0d) want (20,10,c0)", cap_x[0], cap_y[0], cap_c[0]);
        end
        checks++;
        if ({cap_x[41], cap_y[41], cap_c[41]} !== {8'd21, 7'd11, 3'd1}) begin
            failures++; $display("FAIL pixel41: got (%0d,%0d,c%0d) want (21,11,c1)", cap_x[41], cap_y[41], cap_c[41]);
        end
        checks++;
        if ({cap_x[N-1], cap_y[N-1], cap_c[N-1]} !== {8'd59, 7'd49, 3'd7}) begin
            failures++; $display("FAIL last_pixel: got (%0d,%0d,c%0d) want (59,49,c7)", cap_x[N-1], cap_y[N-1], cap_c[N-1]);
        end
    endtask

    task automatic test_ignored_start();
        sweep(3'd3, 8'($urandom), 7'($urandom), 700);
    endtask

    task automatic test_wrap();
        sweep(3'($urandom), 8'd150, 7'd100, -1);
        checks++;
        if ({cap_y[27*W], cap_y[28*W]} !== {7'd127, 7'd0}) begin
            failures++; $display("FAIL y_wrap: rows 27/28 y=%0d/%0d want 127/0", cap_y[27*W], cap_y[28*W]);
        end
        sweep(3'($urandom), 8'd230, 7'd5, -1);
        checks++;
        if ({cap_x[25], cap_x[26]} !== {8'd255, 8'd0}) begin
            failures++; $display("FAIL x_wrap: cols 25/26 x=%0d/%0d want 255/0", cap_x[25], cap_x[26]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2; i++)
            sweep(3'($urandom), 8'($urandom), 7'($urandom), -1);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        icon_in = 3'd6; x_origin = 8'd40; y_origin = 7'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 501; i++) @(negedge clk);
        checks++;
        if ({plot, x, y} !== {1'b1, 8'(40 + 500 % W), 7'(20 + 500 / W)}) begin
            failures++; $display("FAIL pre_reset_pixel: plot=%b (%0d,%0d) want 1 (%0d,%0d)",
                                 plot, x, y, 40 + 500 % W, 20 + 500 / W);
        end
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({plot, busy, done, rom_address, x, y, icon_out} !== 31'd0) begin
            failures++; $display("FAIL mid_reset: plot=%b busy=%b done=%b addr=%0d x=%0d y=%0d icon=%0d want all 0",
                                 plot, busy, done, rom_address, x, y, icon_out);
        end
        resetn = 1'b1;
        for (int i = 0; i < N + 20; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1 || plot === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++; $display("FAIL no_resume: %0d active cycles after reset want 0", seen);
        end
        sweep(3'd2, 8'($urandom), 7'($urandom), -1);
    endtask

    task automatic test_back_to_back();
        int done_t[$];
        int rise_t[$];
        logic [10:0] rise_addr[$];
        int plots = 0;
        logic prev_busy = 1'b0;
        icon_in = 3'd1; x_origin = 8'($urandom); y_origin = 7'($urandom); start = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 2 * (N + 3) + 20; t++) begin
            if (done === 1'b1) done_t.push_back(t);
            if (plot === 1'b1) plots++;
            if (busy === 1'b1 && prev_busy === 1'b0) begin
                rise_t.push_back(t);
                rise_addr.push_back(rom_address);
            end
            prev_busy = busy;
            if (done_t.size() >= 2) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (done_t.size() !== 2) begin
            failures++; $display("FAIL b2b_done_count: got %0d want 2", done_t.size());
        end else begin
            checks++;
            if (done_t[0] !== N + 1) begin
                failures++; $display("FAIL b2b_first_done: at %0d want %0d", done_t[0], N + 1);
            end
            checks++;
            if (done_t[1] - done_t[0] !== N + 3) begin
                failures++; $display("FAIL b2b_done_gap: got %0d want %0d", done_t[1] - done_t[0], N + 3);
            end
        end
        checks++;
        if (plots !== 2 * N) begin
            failures++; $display("FAIL b2b_plots: got %0d want %0d", plots, 2 * N);
        end
        checks++;
        if (rise_t.size() !== 2) begin
            failures++; $display("FAIL b2b_sweeps: got %0d want 2", rise_t.size());
        end else begin
            checks++;
            if (rise_addr[1] !== 11'd0) begin
                failures++; $display("FAIL b2b_addr_restart: got %0d want 0", rise_addr[1]);
            end
        end
    endtask

    initial begin
        start = 1'b0; icon_in = '0; x_origin = '0; y_origin = '0; resetn = 1'b0;
        test_reset();
        test_basic();
        test_ignored_start();
        test_wrap();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
